sdf_r2_stage: RTL and testbench
===============================

# sdf_r2_stage

Radix-2 single-path delay-feedback (SDF) butterfly stage with a programmable feedback delay line and twiddle-address generator. Streams one complex Q6.12 sample per valid cycle and emits the butterfly sum and difference streams in natural SDF order. It sits directly upstream of `Constant_Multiplier_fft`: its `tw_addr` output drives the multiplier's `address` input, aligned sample-for-sample with `out_r`/`out_i`.

## Interface
- `INTEGER_SIZE`, 6: integer bits of the signed fixed-point sample.
- `FRACT_SIZE`, 12: fraction bits; `DATA_WIDTH = INTEGER_SIZE+FRACT_SIZE`.
- `DEPTH`, 4: feedback delay length D. Must be a power of two, ≥4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input sample strobe; the stage advances only when it is high.
- `in_r`, `in_i`  in  DATA_WIDTH  signed input sample.
- `out_valid`  out  1  output strobe.
- `out_r`, `out_i`  out  DATA_WIDTH  signed butterfly output.
- `tw_addr`  out  6  twiddle index for the downstream constant multiplier. Only 0..3 are used; bits [5:2] are always 0.

## Operation
- Phase counter `cnt` runs mod 2·D and increments only on `in_valid`.
- **Phase A** (`cnt < D`):
  - Feedback FIFO writes `in`.
  - Output is the FIFO head, which holds the previous frame's difference a−b.
- **Phase B** (`cnt ≥ D`), with FIFO head `a` and input `b`:
  - Output is a+b.
  - FIFO writes a−b.
- FIFO is a D-entry shift register. It shifts only on `in_valid`; with `in_valid` low all state is held (stall).
- `primed` flag:
  - Cleared by reset.
  - Set on the first accepted Phase-B sample.
  - Phase-A outputs are valid only when `primed` = 1.
- `out_valid` = registered(`in_valid` && (Phase B || `primed`)).
- `tw_addr` is registered with the data:
  - Phase B: 0.
  - Phase A: j >> (log2(D)−2), where j = `cnt`. D=4 therefore gives 0,1,2,3.
- Arithmetic:
  - Real and imaginary parts are handled independently.
  - Each add/sub is computed at DATA_WIDTH+1 bits, then reduced to DATA_WIDTH (see Configuration).
  - No scaling is applied.
- Draining the last frame's differences requires D further valid inputs; the bench feeds zeros.

## Timing
- Reset values:
  - `out_valid`=0, `out_r`=`out_i`=0, `tw_addr`=0.
  - `cnt`=0, `primed`=0, FIFO all zeros.
- Latency: an accepted input produces its output one clock later.
- Input x[n] of frame k:
  - Its sum appears with input sample n+D.
  - Its difference appears with input sample n+2D, i.e. in the next frame's Phase A.
- Wrap: `cnt` = 2D−1 → 0 on a valid input.
- `primed` stays set across frames until reset.
- Stall: while `in_valid`=0, `out_valid` drops the following cycle and all registers hold; data outputs keep their last value.
- Reset mid-frame: the next cycle shows reset values, and the stage restarts at Phase A, unprimed. The partial frame is discarded.
- Simultaneous `rst` and `in_valid`: reset wins and the sample is dropped.

## Configuration
- `SDF_SAT_EN` defined: each sum/difference saturates to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Not defined: two's-complement wrap, i.e. the low DATA_WIDTH bits are kept.

## Structure
- Package `sdf_pkg`:
  - `DATA_WIDTH`, Q-format constants, and `tw_addr` width (6).
  - Function `sat_add` (saturating reduce from DATA_WIDTH+1 bits) under `SDF_SAT_EN`.
  - Phase enum {PH_A, PH_B}.
- Sub-module `sdf_feedback_fifo`: D-deep complex shift register with an enable, synchronous active-high reset, and head output.
- Top: phase counter, `primed` flag, butterfly add/sub, output registers.

## Test plan
All cases use D=4; Q6.12, so 1.0 = 4096.
- **Constant frame:** 16 inputs of 4096+0j.
  - First output appears the cycle after input 4.
  - Outputs 1–4 = 8192, `tw_addr`=0.
  - Outputs 5–8 = 0, `tw_addr` = 0,1,2,3.
- **Impulse:** x = [4096,0,0,0,0,0,0,0], then 4 zeros.
  - Sums = [4096,0,0,0].
  - Diffs = [4096,0,0,0] with `tw_addr` = 0,1,2,3.
  - `out_valid` is high for 8 cycles.
- **Overflow:** a = b = 0x1F000 (≈31.0) in the same butterfly.
  - With `SDF_SAT_EN`: sum = 0x1FFFF (131071).
  - Without: sum wraps to 0x3E000, read as −8192.
- **Stall:** the constant-frame case with `in_valid` toggled 1,0,1,0.
  - Outputs are identical to the unstalled run.
  - `out_valid` is high only the cycle after each accepted sample.
- **Mid-frame reset:** assert `rst` after 6 inputs, then replay the impulse case.
  - The next cycle shows all outputs 0.
  - The replay matches the impulse case exactly, with no stale outputs.
- **Downstream integration:** connect to `Constant_Multiplier_fft`, impulse input.
  - Difference stream x[0]=4096 at `tw_addr` 0 → multiplier output 4096+0j, one cycle later.

Source files
------------

// File: rtl/sdf_pkg.sv
// Shared constants, phase type and saturating reducer for the radix-2 SDF stage.
// Optional feature macro: SDF_SAT_EN (saturating add/sub instead of wrap).
package sdf_pkg;

   localparam int INTEGER_SIZE = 6;
   localparam int FRACT_SIZE   = 12;
   localparam int DATA_WIDTH   = INTEGER_SIZE + FRACT_SIZE;
   localparam int Q_ONE        = 1 << FRACT_SIZE;
   localparam int TW_ADDR_W    = 6;

   typedef enum logic {
      PH_A = 1'b0,
      PH_B = 1'b1
   } phase_e;

`ifdef SDF_SAT_EN
   // Clamp a sign-extended sum to the signed range of a w-bit word; caller keeps the low w bits.
   function automatic logic signed [31:0] sat_add(input logic signed [32:0] s, input int w);
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      hi = (33'sd1 <<< (w - 1)) - 33'sd1;
      lo = -(33'sd1 <<< (w - 1));
      if (s > hi)
         return hi[31:0];
      else if (s < lo)
         return lo[31:0];
      else
         return s[31:0];
   endfunction
`endif

endpackage

// File: rtl/sdf_feedback_fifo.sv
// D-deep complex shift register with shift enable; head is the oldest entry.
module sdf_feedback_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 18
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_en,
   input  logic signed [DW-1:0] i_din_r,
   input  logic signed [DW-1:0] i_din_i,
   output logic signed [DW-1:0] o_head_r,
   output logic signed [DW-1:0] o_head_i
);

   logic signed [DW-1:0] r_mem_r [DEPTH];
   logic signed [DW-1:0] r_mem_i [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_tap
         always_ff @(posedge clk) begin
            if (rst) begin
               r_mem_r[gi] <= '0;
               r_mem_i[gi] <= '0;
            end else if (i_en) begin
               if (gi == 0) begin
                  r_mem_r[gi] <= i_din_r;
                  r_mem_i[gi] <= i_din_i;
               end else begin
                  r_mem_r[gi] <= r_mem_r[(gi > 0) ? gi - 1 : 0];
                  r_mem_i[gi] <= r_mem_i[(gi > 0) ? gi - 1 : 0];
               end
            end
         end
      end
   endgenerate

   assign o_head_r = r_mem_r[DEPTH-1];
   assign o_head_i = r_mem_i[DEPTH-1];

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 SDF butterfly stage: phase counter, primed flag, add/sub, twiddle index.
// Optional feature macro: SDF_SAT_EN (saturate sums/differences instead of wrapping).
module sdf_r2_stage
   import sdf_pkg::*;
#(
   parameter int INTEGER_SIZE = 6,
   parameter int FRACT_SIZE   = 12,
   parameter int DEPTH        = 4
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       in_valid,
   input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]  in_r,
   input  logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]  in_i,
   output logic                                       out_valid,
   output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]  out_r,
   output logic signed [INTEGER_SIZE+FRACT_SIZE-1:0]  out_i,
   output logic [TW_ADDR_W-1:0]                       tw_addr
);

   localparam int DW    = INTEGER_SIZE + FRACT_SIZE;
   localparam int LOG2D = $clog2(DEPTH);
   localparam int CW    = LOG2D + 1;

   logic [CW-1:0]        r_cnt;
   logic                 r_primed;
   logic                 r_out_valid;
   logic signed [DW-1:0] r_out_r;
   logic signed [DW-1:0] r_out_i;
   logic [1:0]           r_tw;

   phase_e               w_phase;
   logic signed [DW-1:0] w_head_r, w_head_i;
   logic signed [DW:0]   w_sum_r, w_sum_i, w_dif_r, w_dif_i;
   logic signed [DW-1:0] w_sum_red_r, w_sum_red_i, w_dif_red_r, w_dif_red_i;
   logic signed [DW-1:0] w_fifo_in_r, w_fifo_in_i;
   logic [1:0]           w_tw;

   // The counter MSB selects the half-frame, so it wraps mod 2*D for free.
   assign w_phase = r_cnt[LOG2D] ? PH_B : PH_A;

   assign w_sum_r = {w_head_r[DW-1], w_head_r} + {in_r[DW-1], in_r};
   assign w_sum_i = {w_head_i[DW-1], w_head_i} + {in_i[DW-1], in_i};
   assign w_dif_r = {w_head_r[DW-1], w_head_r} - {in_r[DW-1], in_r};
   assign w_dif_i = {w_head_i[DW-1], w_head_i} - {in_i[DW-1], in_i};

`ifdef SDF_SAT_EN
   logic signed [31:0] w_sat_sum_r, w_sat_sum_i, w_sat_dif_r, w_sat_dif_i;
   assign w_sat_sum_r = sat_add(33'(w_sum_r), DW);
   assign w_sat_sum_i = sat_add(33'(w_sum_i), DW);
   assign w_sat_dif_r = sat_add(33'(w_dif_r), DW);
   assign w_sat_dif_i = sat_add(33'(w_dif_i), DW);
   assign w_sum_red_r = w_sat_sum_r[DW-1:0];
   assign w_sum_red_i = w_sat_sum_i[DW-1:0];
   assign w_dif_red_r = w_sat_dif_r[DW-1:0];
   assign w_dif_red_i = w_sat_dif_i[DW-1:0];
`else
   assign w_sum_red_r = w_sum_r[DW-1:0];
   assign w_sum_red_i = w_sum_i[DW-1:0];
   assign w_dif_red_r = w_dif_r[DW-1:0];
   assign w_dif_red_i = w_dif_i[DW-1:0];
`endif

   assign w_fifo_in_r = (w_phase == PH_B) ? w_dif_red_r : in_r;
   assign w_fifo_in_i = (w_phase == PH_B) ? w_dif_red_i : in_i;

   // Only four twiddles are used, so the index is the top two bits of the in-half position.
   assign w_tw = 2'(r_cnt[LOG2D-1:0] >> (LOG2D - 2));

   sdf_feedback_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_en     (in_valid),
      .i_din_r  (w_fifo_in_r),
      .i_din_i  (w_fifo_in_i),
      .o_head_r (w_head_r),
      .o_head_i (w_head_i)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_primed    <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_r     <= '0;
         r_out_i     <= '0;
         r_tw        <= '0;
      end else begin
         r_out_valid <= in_valid && ((w_phase == PH_B) || r_primed);
         if (in_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_phase == PH_B) begin
               r_primed <= 1'b1;
               r_out_r  <= w_sum_red_r;
               r_out_i  <= w_sum_red_i;
               r_tw     <= '0;
            end else begin
               r_out_r  <= w_head_r;
               r_out_i  <= w_head_i;
               r_tw     <= w_tw;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_r     = r_out_r;
   assign out_i     = r_out_i;
   assign tw_addr   = {{(TW_ADDR_W-2){1'b0}}, r_tw};

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Self-checking bench for sdf_r2_stage (D=4, Q6.12) against a frame-level reference model.
module tb_sdf_r2_stage;

   localparam int D  = 4;
   localparam int DW = 18;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] in_r = '0;
   logic signed [DW-1:0] in_i = '0;
   logic                 out_valid;
   logic signed [DW-1:0] out_r;
   logic signed [DW-1:0] out_i;
   logic [5:0]           tw_addr;

   always #5 clk = ~clk;

   sdf_r2_stage #(
      .INTEGER_SIZE (6),
      .FRACT_SIZE   (12),
      .DEPTH        (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_r      (in_r),
      .in_i      (in_i),
      .out_valid (out_valid),
      .out_r     (out_r),
      .out_i     (out_i),
      .tw_addr   (tw_addr)
   );

   int checks = 0;
   int failures = 0;
   int nvalid;

   // Reference model: frame position, stored first-half inputs, this and previous frame's differences.
   int m_n;
   bit m_primed;
   int m_frame_r [D];
   int m_frame_i [D];
   int m_diff_r [D];
   int m_diff_i [D];
   int m_prev_r [D];
   int m_prev_i [D];
   int exp_valid, exp_r, exp_i, exp_tw;

   function automatic int red(input int s);
`ifdef SDF_SAT_EN
      if (s > 131071) return 131071;
      if (s < -131072) return -131072;
`endif
      return int'($signed(18'(s)));
   endfunction

   task automatic model_reset();
      m_n = 0;
      m_primed = 0;
      for (int k = 0; k < D; k++) begin
         m_frame_r[k] = 0; m_frame_i[k] = 0;
         m_diff_r[k] = 0;  m_diff_i[k] = 0;
         m_prev_r[k] = 0;  m_prev_i[k] = 0;
      end
      exp_valid = 0; exp_r = 0; exp_i = 0; exp_tw = 0;
   endtask

   task automatic model_accept(input int xr, input int xi);
      if (m_n < D) begin
         exp_r = m_prev_r[m_n];
         exp_i = m_prev_i[m_n];
         exp_tw = m_n;
         exp_valid = m_primed ? 1 : 0;
         m_frame_r[m_n] = xr;
         m_frame_i[m_n] = xi;
      end else begin
         exp_r = red(m_frame_r[m_n-D] + xr);
         exp_i = red(m_frame_i[m_n-D] + xi);
         m_diff_r[m_n-D] = red(m_frame_r[m_n-D] - xr);
         m_diff_i[m_n-D] = red(m_frame_i[m_n-D] - xi);
         exp_tw = 0;
         exp_valid = 1;
         m_primed = 1;
      end
      m_n = (m_n + 1) % (2 * D);
      if (m_n == 0) begin
         m_prev_r = m_diff_r;
         m_prev_i = m_diff_i;
      end
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic step(input logic v, input logic rr, input int xr, input int xi);
      in_valid = v;
      rst = rr;
      in_r = DW'(xr);
      in_i = DW'(xi);
      @(posedge clk);
      if (rr) model_reset();
      else if (v) model_accept(int'(in_r), int'(in_i));
      else exp_valid = 0;
      #1;
      check("out_valid", out_valid, exp_valid);
      check("out_r", out_r, exp_r);
      check("out_i", out_i, exp_i);
      check("tw_addr", tw_addr, exp_tw);
      if (out_valid === 1'b1) nvalid++;
      $display("t=%0t rst=%0b v=%0b in=%0d,%0d -> ov=%0b out=%0d,%0d tw=%0d",
               $time, rr, v, xr, xi, out_valid, out_r, out_i, tw_addr);
   endtask

   task automatic impulse_run();
      nvalid = 0;
      step(1'b1, 1'b0, 4096, 0);
      for (int k = 1; k < 2 * D + D; k++) step(1'b1, 1'b0, 0, 0);
      check("impulse_valid_count", nvalid, 8);
   endtask

   initial begin
      model_reset();
      // Reset state, including a valid sample dropped because reset wins.
      step(1'b0, 1'b1, 0, 0);
      step(1'b1, 1'b1, 1234, 77);

      // Constant frame: 16 inputs of 1.0, then drain.
      for (int k = 0; k < 16; k++) begin
         step(1'b1, 1'b0, 4096, 0);
         if (k == 4) check("const_first_sum", out_r, 8192);
         if (k == 9) check("const_diff_tw1", tw_addr, 1);
      end
      for (int k = 0; k < D; k++) step(1'b1, 1'b0, 0, 0);

      // Impulse from a clean reset.
      step(1'b0, 1'b1, 0, 0);
      impulse_run();

      // Constant frame with in_valid toggling 1,0.
      step(1'b0, 1'b1, 0, 0);
      for (int k = 0; k < 16; k++) begin
         step(1'b1, 1'b0, 4096, 0);
         step(1'b0, 1'b0, 0, 0);
         if (k == 4) check("stall_hold_sum", out_r, 8192);
      end

      // Mid-frame reset after 6 inputs, then replay the impulse.
      step(1'b0, 1'b1, 0, 0);
      for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1000 + k, -500 + k);
      step(1'b1, 1'b1, 999, 999);
      check("midreset_out_r", out_r, 0);
      impulse_run();

      // Overflow: a = b = 0x1F000 in the same butterfly.
      step(1'b0, 1'b1, 0, 0);
      for (int k = 0; k < D; k++) step(1'b1, 1'b0, 'h1F000, 0);
      step(1'b1, 1'b0, 'h1F000, 0);
`ifdef SDF_SAT_EN
      check("overflow_sum", out_r, 131071);
`else
      check("overflow_sum", out_r, -8192);
`endif

      // Randomised traffic: random data, ~70% valid, rare resets.
      step(1'b0, 1'b1, 0, 0);
      for (int k = 0; k < 400; k++) begin
         int unsigned dr, di;
         dr = $urandom;
         di = $urandom;
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0),
              int'($signed(18'(dr))), int'($signed(18'(di))));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
